permute_inv_stream: RTL and testbench
=====================================

# permute_inv_stream

Streaming inverse word permutation for the Threefish-1024 datapath. It accepts a 16-word block of 64-bit words serially, in order y[0]..y[15], and buffers it. It then emits the block serially in inverse-permuted order, x[j] = y[INV[j]] for j = 0..15, which undoes the forward permutation used by the encrypt rounds. The block sits on the decrypt path between the subkey-subtract stage and the inverse-MIX stage, and uses a valid/ready handshake on both sides.

## Interface
Parameters:
- W, 64, word width in bits.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  W  input word y[i]; the index is implicit from arrival order.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word this cycle.
- out_data  out  W  output word x[j].
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts a word this cycle.
- out_last  out  1  high together with out_valid on word j = 15.

## Operation
- Inverse table, j -> INV[j]: 0,15,2,11,6,13,4,9,14,1,8,5,10,3,12,7.
  - This is the inverse of the forward permutation π = 0,9,2,13,6,11,4,15,10,7,12,3,14,5,8,1.
- Storage is organised as banks of 16 x W registers. Each bank has a full flag.
- Fill side, counter wr_idx[3:0]:
  - A word is accepted when in_valid && in_ready. It is written to bank[fill_bank][wr_idx], then wr_idx increments.
  - When wr_idx == 15 is accepted: set full[fill_bank], wr_idx wraps to 0, fill_bank toggles (pingpong build only).
  - in_ready = !full[fill_bank].
- Drain side, counter rd_idx[3:0]:
  - out_valid = full[drain_bank].
  - out_data = bank[drain_bank][INV[rd_idx]].
  - out_last = out_valid && (rd_idx == 15).
  - A word transfers when out_valid && out_ready; rd_idx then increments.
  - When rd_idx == 15 transfers: clear full[drain_bank], rd_idx wraps to 0, drain_bank toggles (pingpong build only).
- Per-bank state is FILLING (full = 0) or DRAINING (full = 1):
  - FILLING -> DRAINING on acceptance of the 16th word.
  - DRAINING -> FILLING on transfer of the 16th word.
- Simultaneous set and clear on the same bank cannot occur. Set requires full = 0 and clear requires full = 1.
- Set on one bank and clear on the other bank in the same cycle both take effect.
- Data is never modified; the block only reorders words.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_last = 0, out_data = don't-care.
  - All full flags, wr_idx, rd_idx, fill_bank and drain_bank reset to 0.
  - Bank contents are not reset.
- Latency: out_valid rises on the cycle after the 16th input word is accepted.
- out_data and out_last are combinational from registered state (bank, rd_idx). There is no combinational path from in_* to out_*.
- in_ready does not depend combinationally on out_ready.
- Handshake rules:
  - out_data and out_last hold stable while out_valid && !out_ready.
  - in_valid may be deasserted mid-block; partial fill is retained until the block completes.
- Reset mid-operation: all buffered words and partial blocks are discarded. The cycle after rst deasserts, the block is in the reset state.
- Throughput:
  - Single-bank build: 16 fill cycles, then 16 drain cycles. in_ready is low throughout the drain.
  - Pingpong build: sustained 1 word/cycle on both sides.

## Configuration
- Macro: PERMUTE_INV_PINGPONG_EN.
- Defined: two banks.
  - fill_bank and drain_bank toggle as described in Operation.
  - The next block fills while the current block drains.
- Undefined: one bank.
  - fill_bank and drain_bank are tied to 0.
  - in_ready is low from the cycle after the 16th word is accepted until the cycle after the 16th word drains.
- Handshake semantics and output ordering are identical in both builds.

## Structure
- Shared package, permute_pkg:
  - NWORDS = 16.
  - IDX_W = 4.
  - The forward table PI[0:15] and the inverse table INV[0:15] as localparam arrays, so the encrypt-side select logic and this block share one source of truth.
- Sub-module permute_inv_select: combinational, 4-bit j in, 4-bit INV[j] out, implemented as a case on j. All other logic lives in permute_inv_stream.

## Test plan
- Single block, out_ready = 1: input y[i] = 64'h1000 + i.
  - Outputs in order: 1000, 100F, 1002, 100B, 1006, 100D, 1004, 1009, 100E, 1001, 1008, 1005, 100A, 1003, 100C, 1007.
  - out_last only on the last output. First out_valid is exactly 1 cycle after the 16th accept.
- Backpressure: out_ready toggles 1,0,0,1 repeating.
  - out_data and out_last are stable while stalled; the sequence is unchanged; no word is dropped or duplicated.
- Round trip: random 16 words through a forward-π model, then through the DUT.
  - Output equals the original words in index order. Repeat for 100 blocks.
- Back-to-back blocks, in_valid = 1 and out_ready = 1 continuously:
  - Pingpong build: in_ready never drops; 2 blocks take 16 + 32 cycles.
  - Single-bank build: in_ready is low for exactly 16 cycles per block.
- Reset mid-operation: assert rst after 7 words in, and separately after 5 words out.
  - Next cycle: in_ready = 1, out_valid = 0.
  - A fresh block then drains correctly with no stale words.
- Gapped input: in_valid asserted 1 cycle in 3.
  - Output is identical to the first scenario; out_valid stays 0 until the 16th accept.

Source files
------------

// File: rtl/permute_pkg.sv
// Shared word-permutation tables for the Threefish-1024 datapath.
// PI is the forward (encrypt) word permutation; INV is its inverse.
package permute_pkg;

    localparam int unsigned NWORDS = 16;
    localparam int unsigned IDX_W  = 4;

    // Encrypt rounds: y[i] = x[PI[i]]
    localparam logic [IDX_W-1:0] PI [NWORDS] = '{
        4'd0,  4'd9,  4'd2,  4'd13, 4'd6,  4'd11, 4'd4,  4'd15,
        4'd10, 4'd7,  4'd12, 4'd3,  4'd14, 4'd5,  4'd8,  4'd1
    };

    // Decrypt path: x[j] = y[INV[j]], so PI[INV[j]] == j
    localparam logic [IDX_W-1:0] INV [NWORDS] = '{
        4'd0,  4'd15, 4'd2,  4'd11, 4'd6,  4'd13, 4'd4,  4'd9,
        4'd14, 4'd1,  4'd8,  4'd5,  4'd10, 4'd3,  4'd12, 4'd7
    };

    // A bank is FILLING while its full flag is clear, DRAINING while set
    typedef enum logic {
        FILLING  = 1'b0,
        DRAINING = 1'b1
    } bank_state_e;

endpackage

// File: rtl/permute_inv_select.sv
// Combinational inverse-permutation index lookup: sel = INV[j].
module permute_inv_select
    import permute_pkg::*;
(
    input  logic [IDX_W-1:0] j,
    output logic [IDX_W-1:0] sel
);

    always_comb begin
        sel = '0;
        case (j)
            4'd0:    sel = 4'd0;
            4'd1:    sel = 4'd15;
            4'd2:    sel = 4'd2;
            4'd3:    sel = 4'd11;
            4'd4:    sel = 4'd6;
            4'd5:    sel = 4'd13;
            4'd6:    sel = 4'd4;
            4'd7:    sel = 4'd9;
            4'd8:    sel = 4'd14;
            4'd9:    sel = 4'd1;
            4'd10:   sel = 4'd8;
            4'd11:   sel = 4'd5;
            4'd12:   sel = 4'd10;
            4'd13:   sel = 4'd3;
            4'd14:   sel = 4'd12;
            4'd15:   sel = 4'd7;
            default: sel = '0;
        endcase
    end

endmodule

// File: rtl/permute_inv_stream.sv
// Streaming inverse word permutation: buffers 16 words, emits x[j] = y[INV[j]].
// Define PERMUTE_INV_PINGPONG_EN for two banks (fill one while draining the other).
module permute_inv_stream
    import permute_pkg::*;
#(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last
);

`ifdef PERMUTE_INV_PINGPONG_EN
    localparam int unsigned NBANKS = 2;
`else
    localparam int unsigned NBANKS = 1;
`endif
    localparam int unsigned BANK_W = 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    logic [W-1:0]      bank_q [NBANKS][NWORDS];
    bank_state_e       state_q [NBANKS];
    bank_state_e       state_d [NBANKS];
    logic [NBANKS-1:0] full;

    logic [IDX_W-1:0]  wr_idx_q;
    logic [IDX_W-1:0]  rd_idx_q;
    logic [IDX_W-1:0]  inv_idx;
    logic [BANK_W-1:0] fill_bank;
    logic [BANK_W-1:0] drain_bank;

    logic in_fire;
    logic out_fire;
    logic fill_done;
    logic drain_done;

    // Handshake decode; both sides depend only on registered bank state
    always_comb begin
        for (int unsigned b = 0; b < NBANKS; b++) begin
            full[b] = (state_q[b] == DRAINING);
        end
    end

    assign in_ready   = !full[fill_bank];
    assign out_valid  = full[drain_bank];
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign fill_done  = in_fire && (wr_idx_q == LAST_IDX);
    assign drain_done = out_fire && (rd_idx_q == LAST_IDX);

    // Per-bank state register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned b = 0; b < NBANKS; b++) begin
                state_q[b] <= FILLING;
            end
        end else begin
            for (int unsigned b = 0; b < NBANKS; b++) begin
                state_q[b] <= state_d[b];
            end
        end
    end

    // Set and clear can never hit the same bank: set needs FILLING, clear needs DRAINING
    always_comb begin
        for (int unsigned b = 0; b < NBANKS; b++) begin
            state_d[b] = state_q[b];
            case (state_q[b])
                FILLING: begin
                    if (fill_done && (fill_bank == BANK_W'(b))) begin
                        state_d[b] = DRAINING;
                    end
                end
                DRAINING: begin
                    if (drain_done && (drain_bank == BANK_W'(b))) begin
                        state_d[b] = FILLING;
                    end
                end
                default: state_d[b] = FILLING;
            endcase
        end
    end

    // Fill and drain word counters wrap naturally at 16
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
        end else begin
            if (in_fire) begin
                wr_idx_q <= wr_idx_q + IDX_W'(1);
            end
            if (out_fire) begin
                rd_idx_q <= rd_idx_q + IDX_W'(1);
            end
        end
    end

`ifdef PERMUTE_INV_PINGPONG_EN
    // Bank pointers advance once per completed block on each side
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_bank  <= '0;
            drain_bank <= '0;
        end else begin
            if (fill_done) begin
                fill_bank <= ~fill_bank;
            end
            if (drain_done) begin
                drain_bank <= ~drain_bank;
            end
        end
    end
`else
    assign fill_bank  = '0;
    assign drain_bank = '0;
`endif

    // Word storage; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (in_fire && !rst) begin
            bank_q[fill_bank][wr_idx_q] <= in_data;
        end
    end

    permute_inv_select u_select (
        .j   (rd_idx_q),
        .sel (inv_idx)
    );

    assign out_data = bank_q[drain_bank][inv_idx];
    assign out_last = out_valid && (rd_idx_q == LAST_IDX);

endmodule

// File: tb/tb_permute_inv_stream.sv
// Directed self-checking bench for permute_inv_stream (either bank build).
module tb_permute_inv_stream;

    typedef logic [63:0] blk_t [16];

    logic        clk;
    logic        rst;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    int n_cmp;
    int n_err;

    // Forward permutation used only to build round-trip stimulus
    logic [3:0] pi_tb [16] = '{
        4'd0,  4'd9,  4'd2,  4'd13, 4'd6,  4'd11, 4'd4,  4'd15,
        4'd10, 4'd7,  4'd12, 4'd3,  4'd14, 4'd5,  4'd8,  4'd1
    };

    blk_t seq1;
    blk_t exp1;

    permute_inv_stream #(.W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one block and drain it, checking order, out_last, latency and stall stability
    task automatic run_block(input string tag, input blk_t din, input blk_t dexp,
                             input int gap, input bit bp);
        int          n_in;
        int          k;
        int          cyc;
        bit          filled;
        bit          first_seen;
        bit          stalled;
        logic [63:0] pd;
        logic        pl;
        n_in = 0; k = 0; cyc = 0;
        filled = 1'b0; first_seen = 1'b0; stalled = 1'b0;
        pd = '0; pl = 1'b0;
        while (k < 16 && cyc < 400) begin
            in_valid  = (n_in < 16) && (cyc % gap == 0);
            in_data   = (n_in < 16) ? din[4'(n_in)] : 64'h0;
            out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (!filled) begin
                chk({tag, "/early_valid"}, 64'(out_valid), 64'd0);
            end else if (!first_seen) begin
                chk({tag, "/latency"}, 64'(out_valid), 64'd1);
                first_seen = 1'b1;
            end
            if (stalled) begin
                chk({tag, "/stall_data"}, out_data, pd);
                chk({tag, "/stall_last"}, 64'(out_last), 64'(pl));
            end
            if (out_valid) begin
                chk({tag, "/data"}, out_data, dexp[4'(k)]);
                chk({tag, "/last"}, 64'(out_last), 64'(k == 15));
            end
            stalled = out_valid && !out_ready;
            pd      = out_data;
            pl      = out_last;
            if (out_valid && out_ready) k++;
            if (in_valid && in_ready) n_in++;
            tick();
            if (n_in == 16) filled = 1'b1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk({tag, "/words_out"}, 64'(k), 64'd16);
    endtask

    initial begin
        blk_t x;
        blk_t y;
        int   cyc;
        int   n_in;
        int   k;
        int   low;
        int   total;
        int   exp_total;
        int   exp_low;

        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        for (int i = 0; i < 16; i++) seq1[i] = 64'h1000 + 64'(i);
        exp1 = '{64'h1000, 64'h100F, 64'h1002, 64'h100B, 64'h1006, 64'h100D, 64'h1004, 64'h1009,
                 64'h100E, 64'h1001, 64'h1008, 64'h1005, 64'h100A, 64'h1003, 64'h100C, 64'h1007};

        // Reset state
        repeat (3) tick();
        chk("reset/in_ready", 64'(in_ready), 64'd1);
        chk("reset/out_valid", 64'(out_valid), 64'd0);
        chk("reset/out_last", 64'(out_last), 64'd0);
        rst = 1'b0;
        tick();

        // Single block, out_ready held high
        run_block("single", seq1, exp1, 1, 1'b0);

        // Backpressure pattern 1,0,0,1
        run_block("backpressure", seq1, exp1, 1, 1'b1);

        // Gapped input, one valid cycle in three
        run_block("gapped", seq1, exp1, 3, 1'b0);

        // Round trip through the forward permutation
        for (int b = 0; b < 100; b++) begin
            for (int i = 0; i < 16; i++) x[i] = {$urandom(), $urandom()};
            for (int i = 0; i < 16; i++) y[i] = x[pi_tb[i]];
            run_block("roundtrip", y, x, 1, 1'b0);
        end

        // Back-to-back blocks with in_valid and out_ready held high
`ifdef PERMUTE_INV_PINGPONG_EN
        exp_total = 48;
        exp_low   = 0;
`else
        exp_total = 64;
        exp_low   = 32;
`endif
        cyc = 0; n_in = 0; k = 0; low = 0; total = 0;
        while (k < 32 && cyc < 200) begin
            in_valid  = (n_in < 32);
            in_data   = (n_in < 16) ? (64'h1000 + 64'(n_in)) : (64'h2000 + 64'(n_in - 16));
            out_ready = 1'b1;
            if (!in_ready) low++;
            if (out_valid) begin
                chk("b2b/data", out_data,
                    (k < 16) ? exp1[4'(k)] : (exp1[4'(k - 16)] + 64'h1000));
                chk("b2b/last", 64'(out_last), 64'((k % 16) == 15));
            end
            if (out_valid && out_ready) begin
                k++;
                if (k == 32) total = cyc + 1;
            end
            if (in_valid && in_ready) n_in++;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b/cycles", 64'(total), 64'(exp_total));
        chk("b2b/ready_low", 64'(low), 64'(exp_low));

        // Reset after 7 words in
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = 64'hBAD0 + 64'(i);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_in/in_ready", 64'(in_ready), 64'd1);
        chk("rst_in/out_valid", 64'(out_valid), 64'd0);
        tick();
        chk("rst_in/in_ready2", 64'(in_ready), 64'd1);
        chk("rst_in/out_valid2", 64'(out_valid), 64'd0);
        run_block("rst_in/fresh", seq1, exp1, 1, 1'b0);

        // Reset after 5 words out
        for (int i = 0; i < 16; i++) begin
            chk("rst_out/fill_ready", 64'(in_ready), 64'd1);
            in_valid = 1'b1;
            in_data  = 64'hBAD0_0000 + 64'(i);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("rst_out/drain_valid", 64'(out_valid), 64'd1);
            tick();
        end
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_out/in_ready", 64'(in_ready), 64'd1);
        chk("rst_out/out_valid", 64'(out_valid), 64'd0);
        chk("rst_out/out_last", 64'(out_last), 64'd0);
        run_block("rst_out/fresh", seq1, exp1, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
